// File: rtl/cfg_lut_cell.sv
// cfg_lut_cell: K-input LUT cell with a serially loaded configuration chain,
// optional output register and inverter. Define LUT_CE_EN to add a register clock enable (ce).
`timescale 1ns/1ps
module cfg_lut_cell #(
    parameter int INPUTS = 4
) (
    input  logic              clock,
    input  logic              rst,
    input  logic              cfg_en,
    input  logic              cfg_in,
    output logic              cfg_out,
    output logic              cfg_done,
`ifdef LUT_CE_EN
    input  logic              ce,
`endif
    input  logic [INPUTS-1:0] in,
    output logic              out
);
    localparam int TT_BITS    = 1 << INPUTS;
    localparam int CONF_BITS  = TT_BITS + 2;
    localparam int REGSEL_BIT = TT_BITS;
    localparam int INV_BIT    = TT_BITS + 1;
    localparam int CW         = $clog2(CONF_BITS + 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(CONF_BITS);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    generate
        if (INPUTS < 2 || INPUTS > 6) begin : g_bad_inputs
            $error("cfg_lut_cell: INPUTS must be in 2..6");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE,
        LOADING,
        ACTIVE
    } state_t;

    state_t               r_state;
    logic [CW-1:0]        r_cnt;
    logic [CONF_BITS-1:0] r_conf;
    logic                 r_reg;

    logic [TT_BITS-1:0]   w_truth;
    logic                 w_lut;
    logic                 w_active;
    logic                 w_ce;

    assign w_truth  = r_conf[TT_BITS-1:0];
    assign w_lut    = w_truth[in];
    assign w_active = (r_state == ACTIVE);

`ifdef LUT_CE_EN
    assign w_ce = ce;
`else
    assign w_ce = 1'b1;
`endif

    // NOTE: sequential state uses <= so every register samples pre-edge values,
    // which is what makes the daisy chain shift exactly one bit per cell per edge.
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            r_conf <= '0;
        end else if (cfg_en) begin
            r_conf <= {cfg_in, r_conf[CONF_BITS-1:1]};
        end
    end

    // A load only counts as complete if cfg_en drops with the counter saturated.
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            unique case (r_state)
                IDLE, ACTIVE: begin
                    if (cfg_en) begin
                        r_state <= LOADING;
                        r_cnt   <= CNT_ONE;
                    end
                end
                LOADING: begin
                    if (cfg_en) begin
                        if (r_cnt != CNT_FULL) begin
                            r_cnt <= r_cnt + CNT_ONE;
                        end
                    end else begin
                        r_state <= (r_cnt == CNT_FULL) ? ACTIVE : IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Cleared outside ACTIVE so the first registered output after a load is INV^0.
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            r_reg <= 1'b0;
        end else if (!w_active) begin
            r_reg <= 1'b0;
        end else if (w_ce) begin
            r_reg <= w_lut;
        end
    end

    // NOTE: give every always_comb output a default first so no path infers a latch.
    always_comb begin
        out = 1'b0;
        if (w_active) begin
            out = r_conf[INV_BIT] ^ (r_conf[REGSEL_BIT] ? r_reg : w_lut);
        end
    end

    assign cfg_out  = r_conf[0];
    assign cfg_done = w_active;

endmodule

// File: tb/tb_cfg_lut_cell.sv
// tb_cfg_lut_cell: two daisy-chained cfg_lut_cell instances (INPUTS=4) checked
// against a scoreboard of expected outputs.
`timescale 1ns/1ps
module tb_cfg_lut_cell;
    logic       clock;
    logic       rst;
    logic       en1;
    logic       en2;
    logic       cfg_in1;
    logic       ce;
    logic [3:0] lut_in;
    logic       c1_cfg_out, c1_done, c1_out;
    logic       c2_cfg_out, c2_done, c2_out;

    int total = 0;
    int bad   = 0;

    typedef struct {
        string       tag;
        logic [31:0] exp;
    } exp_t;
    exp_t sb_q[$];

    cfg_lut_cell #(.INPUTS(4)) u_c1 (
        .clock    (clock),
        .rst      (rst),
        .cfg_en   (en1),
        .cfg_in   (cfg_in1),
        .cfg_out  (c1_cfg_out),
        .cfg_done (c1_done),
`ifdef LUT_CE_EN
        .ce       (ce),
`endif
        .in       (lut_in),
        .out      (c1_out)
    );

    cfg_lut_cell #(.INPUTS(4)) u_c2 (
        .clock    (clock),
        .rst      (rst),
        .cfg_en   (en2),
        .cfg_in   (c1_cfg_out),
        .cfg_out  (c2_cfg_out),
        .cfg_done (c2_done),
`ifdef LUT_CE_EN
        .ce       (ce),
`endif
        .in       (lut_in),
        .out      (c2_out)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic sb_push(input string tag, input logic [31:0] exp);
        exp_t e;
        e.tag = tag;
        e.exp = exp;
        sb_q.push_back(e);
    endtask

    task automatic sb_pop(input logic [31:0] got);
        exp_t e;
        if (sb_q.size() == 0) begin
            check("sb_underflow", 32'd1, 32'd0);
        end else begin
            e = sb_q.pop_front();
            check(e.tag, got, e.exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Send n bits LSB first; bit 0 ends up deepest in the chain.
    task automatic load(input logic [35:0] d, input int n, input bit both);
        for (int i = 0; i < n; i++) begin
            cfg_in1 = d[i];
            en1     = 1'b1;
            en2     = both;
            step();
        end
        en1 = 1'b0;
        en2 = 1'b0;
    endtask

    task automatic sweep_c1(input string tag, input logic [15:0] truth, input logic inv,
                            input bit active);
        for (int i = 0; i < 16; i++) begin
            @(negedge clock);
            lut_in = 4'(i);
            sb_push(tag, active ? 32'(inv ^ truth[i]) : 32'd0);
            #1;
            sb_pop(32'(c1_out));
        end
    endtask

    localparam logic [17:0] CFG_AND4  = {1'b0, 1'b0, 16'h8000};
    localparam logic [17:0] CFG_XOR4R = {1'b1, 1'b1, 16'h6996};
    localparam logic [17:0] CFG_NOR4  = {1'b1, 1'b0, 16'hFFFE};
    localparam logic [17:0] CFG_EQ    = {1'b0, 1'b0, 16'h8001};
    localparam logic [17:0] CFG_AND4R = {1'b0, 1'b1, 16'h8000};

    initial begin
        rst = 1'b1; en1 = 1'b0; en2 = 1'b0; cfg_in1 = 1'b0; ce = 1'b1; lut_in = 4'h0;

        // Reset state and no-load sweep
        #2;
        sb_push("rst_done", 0);  sb_pop(32'(c1_done));
        sb_push("rst_cfgout", 0); sb_pop(32'(c1_cfg_out));
        sb_push("rst_out", 0);   sb_pop(32'(c1_out));
        step();
        rst = 1'b0;
        sweep_c1("noload_out", 16'h0, 1'b0, 1'b0);
        sb_push("noload_done", 0); sb_pop(32'(c1_done));
        sb_push("noload_cfgout", 0); sb_pop(32'(c1_cfg_out));
        step();

        // AND4, combinational, non-inverted
        load(36'(CFG_AND4), 18, 1'b0);
        sb_push("and_loading_done", 0); sb_pop(32'(c1_done));
        step();
        sb_push("and_done", 1); sb_pop(32'(c1_done));
        lut_in = 4'hF; sb_push("and_F", 1); #1; sb_pop(32'(c1_out));
        lut_in = 4'hE; sb_push("and_E", 0); #1; sb_pop(32'(c1_out));
        sweep_c1("and_sweep", CFG_AND4[15:0], CFG_AND4[17], 1'b1);
        sb_push("and_cfgout", 32'(CFG_AND4[0])); sb_pop(32'(c1_cfg_out));

        // cfg_en in ACTIVE gates the output on the next edge, then XOR4 registered+inverted
        step();
        lut_in  = 4'hF;
        cfg_in1 = CFG_XOR4R[0];
        en1     = 1'b1;
        sb_push("reload_out", 0);
        sb_push("reload_done", 0);
        step();
        sb_pop(32'(c1_out));
        sb_pop(32'(c1_done));
        load(36'(CFG_XOR4R >> 1), 17, 1'b0);
        step();
        lut_in = 4'h1;
        sb_push("xor_first", 1);
        sb_push("xor_reg1", 0);
        #1; sb_pop(32'(c1_out));
        step(); sb_pop(32'(c1_out));
        lut_in = 4'h0;
        sb_push("xor_hold", 0);
        sb_push("xor_reg0", 1);
        #1; sb_pop(32'(c1_out));
        step(); sb_pop(32'(c1_out));
        lut_in = 4'h7;
        sb_push("xor_reg7", 0);
        step(); sb_pop(32'(c1_out));

        // Partial load falls back to IDLE
        load(36'(CFG_AND4), 10, 1'b0);
        step();
        sb_push("partial_done", 0); sb_pop(32'(c1_done));
        sweep_c1("partial_out", 16'h0, 1'b0, 1'b0);
        step();

        // Two-cell chain, 36 bits; first 18 shifted land in cell 2
        load({CFG_NOR4, CFG_EQ}, 36, 1'b1);
        step();
        sb_push("chain_c1_done", 1); sb_pop(32'(c1_done));
        sb_push("chain_c2_done", 1); sb_pop(32'(c2_done));
        sb_push("chain_c1_cfgout", 32'(CFG_NOR4[0])); sb_pop(32'(c1_cfg_out));
        sb_push("chain_c2_cfgout", 32'(CFG_EQ[0]));   sb_pop(32'(c2_cfg_out));
        for (int k = 0; k < 3; k++) begin
            logic [3:0] a;
            a = (k == 0) ? 4'h0 : (k == 1) ? 4'hF : 4'h5;
            lut_in = a;
            sb_push("chain_c1_out", 32'(CFG_NOR4[17] ^ CFG_NOR4[a]));
            sb_push("chain_c2_out", 32'(CFG_EQ[17] ^ CFG_EQ[a]));
            #1;
            sb_pop(32'(c1_out));
            sb_pop(32'(c2_out));
        end

        // Async reset mid-load (cnt=9) with cell 2 still ACTIVE
        lut_in = 4'h0;
        load(36'd0, 9, 1'b0);
        sb_push("midload_cfgout", 32'(CFG_NOR4[9])); sb_pop(32'(c1_cfg_out));
        sb_push("midload_c2_out", 1); sb_pop(32'(c2_out));
        #2;
        rst = 1'b1;
        #1;
        sb_push("arst_c1_done", 0); sb_pop(32'(c1_done));
        sb_push("arst_c1_out", 0);  sb_pop(32'(c1_out));
        sb_push("arst_c2_done", 0); sb_pop(32'(c2_done));
        sb_push("arst_c2_out", 0);  sb_pop(32'(c2_out));
        sb_push("arst_cfgout", 0);  sb_pop(32'(c1_cfg_out));
        #1;
        rst = 1'b0;
        step();
        load(36'(CFG_AND4), 18, 1'b0);
        step();
        sb_push("post_rst_done", 1); sb_pop(32'(c1_done));
        lut_in = 4'hF; sb_push("post_rst_F", 1); #1; sb_pop(32'(c1_out));
        lut_in = 4'hE; sb_push("post_rst_E", 0); #1; sb_pop(32'(c1_out));

        // Registered non-inverted AND4; optional clock-enable hold
        step();
        load(36'(CFG_AND4R), 18, 1'b0);
        step();
        lut_in = 4'hF;
        sb_push("reg_first", 0);
        sb_push("reg_F", 1);
        #1; sb_pop(32'(c1_out));
        step(); sb_pop(32'(c1_out));
`ifdef LUT_CE_EN
        ce = 1'b0;
        lut_in = 4'h0;
        sb_push("ce_hold1", 1);
        sb_push("ce_hold2", 1);
        sb_push("ce_resume", 0);
        step(); sb_pop(32'(c1_out));
        step(); sb_pop(32'(c1_out));
        ce = 1'b1;
        step(); sb_pop(32'(c1_out));
`endif

        if (sb_q.size() != 0) begin
            check("sb_leftover", 32'(sb_q.size()), 32'd0);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
